// File: rtl/count_core.sv
// Loadable up/down modulo counter with a valid/ready command port and a small result FIFO.
// Optional build macro COUNT_SAT_EN: saturate at 0 / MAX_COUNT instead of wrapping.
module count_core #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 11,
  parameter int RES_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             clr_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_wrap,
  output logic [WIDTH-1:0] count,
  output logic             err,
  output logic             state_dbg
);

  localparam int AW = $clog2(RES_DEPTH);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(RES_DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_ERR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] nxt_count;
  logic             nxt_wrap, load_bad;
  logic [WIDTH:0]   mem [RES_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic             empty, full, push, pop, accept;

  // Handshakes: a beat transfers on the rising edge where valid && ready are both high;
  // the sender holds valid and payload until then, and ready may depend combinationally on
  // the other port (cmd_ready uses res_ready so a full FIFO can still take a command on a pop).
  assign empty     = (occ == '0);
  assign full      = (occ == DEPTH_V);
  assign pop       = !empty && res_ready;
  assign cmd_ready = (state_q == ST_RUN) && (!full || pop);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    nxt_count = count_q;
    nxt_wrap  = 1'b0;
    load_bad  = 1'b0;
    case (cmd_op)
      2'b01: begin
        if (count_q == MAX_V) begin
`ifdef COUNT_SAT_EN
          nxt_count = MAX_V;
`else
          nxt_count = '0;
`endif
          nxt_wrap = 1'b1;
        end else begin
          nxt_count = count_q + 1'b1;
        end
      end
      2'b10: begin
        if (count_q == '0) begin
`ifdef COUNT_SAT_EN
          nxt_count = '0;
`else
          nxt_count = MAX_V;
`endif
          nxt_wrap = 1'b1;
        end else begin
          nxt_count = count_q - 1'b1;
        end
      end
      2'b11: begin
        if (cmd_data > MAX_V) load_bad = 1'b1;
        else                  nxt_count = cmd_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    push    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (load_bad) begin
            state_d = ST_ERR;
          end else begin
            count_d = nxt_count;
            push    = 1'b1;
          end
        end
      end
      ST_ERR: begin
        if (clr_err) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= {nxt_wrap, nxt_count};
  end

  assign res_valid = !empty;
  assign res_data  = empty ? '0 : mem[rd_ptr][WIDTH-1:0];
  assign res_wrap  = empty ? 1'b0 : mem[rd_ptr][WIDTH];
  assign count     = count_q;
  assign err       = (state_q == ST_ERR);
  assign state_dbg = (state_q == ST_ERR);

endmodule

// File: tb/tb_count_core.sv
// Scoreboard bench for count_core: the driver pushes hand-computed results, a monitor pops on each result beat.
module tb_count_core;
  localparam int W = 4;
  localparam logic [1:0] OP_HOLD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_LOAD = 2'b11;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = OP_HOLD;
  logic [W-1:0] cmd_data = '0;
  logic         clr_err = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_wrap;
  logic [W-1:0] count;
  logic         err;
  logic         state_dbg;

  logic [W:0]   exp_q[$];
  logic [W:0]   exp_e;
  int           n_pass = 0;
  int           n_total = 0;
  int           stall_cycles = 0;

  count_core #(.WIDTH(W), .MAX_COUNT(11), .RES_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .clr_err(clr_err), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_wrap(res_wrap), .count(count),
    .err(err), .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // driver: call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [1:0] op, input logic [W-1:0] data,
                      input logic [W-1:0] ed, input logic ew, input bit exp_push);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clock);
    while (!cmd_ready && waited < 100) begin
      waited++;
      @(negedge clock);
    end
    if (!cmd_ready) check("send_timeout", cmd_ready, 1);
    else if (exp_push) exp_q.push_back({ew, ed});
    stall_cycles += waited;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check("res_data", res_data, exp_e[W-1:0]);
          check("res_wrap", res_wrap, exp_e[W]);
        end
      end else if (!res_valid) begin
        check("empty_data", res_data, 0);
        check("empty_wrap", res_wrap, 0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_count", count, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(posedge clock);
    #1;

    // 12 UPs: 1..11 then 0 with wrap
    res_ready = 1'b1;
    stall_cycles = 0;
    for (int i = 1; i <= 12; i++)
      send(OP_UP, '0, W'(i % 12), (i == 12), 1'b1);
    check("up_no_stall", stall_cycles, 0);
    drain();
    check("up_count", count, 0);

    // LOAD 5 then 6 DOWNs
    send(OP_LOAD, 4'd5, 4'd5, 1'b0, 1'b1);
    for (int i = 4; i >= 0; i--) send(OP_DOWN, '0, W'(i), 1'b0, 1'b1);
`ifdef COUNT_SAT_EN
    send(OP_DOWN, '0, 4'd0, 1'b1, 1'b1);
`else
    send(OP_DOWN, '0, 4'd11, 1'b1, 1'b1);
`endif
    send(OP_HOLD, 4'd9, count, 1'b0, 1'b1);
    drain();

    // backpressure: fill FIFO, stall, then pop and push on the same edge
    send(OP_LOAD, 4'd0, 4'd0, 1'b0, 1'b1);
    drain();
    res_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(OP_UP, '0, W'(i), 1'b0, 1'b1);
    fork
      send(OP_UP, '0, 4'd5, 1'b0, 1'b1);
      begin
        repeat (3) begin
          @(negedge clock);
          check("full_cmd_ready", cmd_ready, 0);
          check("full_head_stable", res_data, 1);
          check("full_count", count, 4);
        end
        @(posedge clock);
        #1 res_ready = 1'b1;
      end
    join
    drain();

    // illegal LOAD -> ERR
    send(OP_LOAD, 4'd13, '0, 1'b0, 1'b0);
    @(negedge clock);
    check("err_set", err, 1);
    check("err_state_dbg", state_dbg, 1);
    check("err_cmd_ready", cmd_ready, 0);
    check("err_count_hold", count, 5);
    check("err_no_result", res_valid, 0);
    @(posedge clock);
    #1;
    cmd_valid = 1'b1;
    cmd_op = OP_UP;
    repeat (2) @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    check("err_ignores_cmd", count, 5);
    @(posedge clock);
    #1 clr_err = 1'b1;
    @(posedge clock);
    #1 clr_err = 1'b0;
    @(negedge clock);
    check("clr_err", err, 0);
    check("clr_cmd_ready", cmd_ready, 1);
    @(posedge clock);
    #1;
    send(OP_LOAD, 4'd7, 4'd7, 1'b0, 1'b1);
    drain();

    // reset with queued results and a command offered
    res_ready = 1'b0;
    for (int i = 8; i <= 10; i++) send(OP_UP, '0, W'(i), 1'b0, 1'b1);
    cmd_valid = 1'b1;
    cmd_op = OP_UP;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clock);
    check("rst2_res_valid", res_valid, 0);
    check("rst2_count", count, 0);
    check("rst2_err", err, 0);
    res_ready = 1'b1;
    @(posedge clock);
    #1;
    send(OP_UP, '0, 4'd1, 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
